// File: rtl/exp_taylor_engine.sv
// ---------------------------------------------------------------------------
// exp_taylor_engine
//
// Evaluates e^x for an unsigned Q0.16 operand with a truncated Taylor series:
//   term_0 = 1.0,  term_(n+1) = term_n * x * 1/(n+1),  result = sum of terms
// The 1/(n+1) coefficients come from an external reciprocal LUT. This block
// drives the LUT address and consumes the combinational coefficient that
// comes back.
//
// Each iteration takes two cycles. In MULX the block multiplies by x. In
// MULC it multiplies by the LUT coefficient and adds the term to the
// accumulator. Every multiply is unsigned and truncating, so the result is
// always at or below the true value.
//
// Parameters:
//   N_TERMS   number of series iterations after the constant 1.0 term (1..8)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     operation request, sampled only in IDLE
//   x         operand, unsigned Q0.16, captured on an accepted start
//   lut_adr   coefficient address to the reciprocal LUT (equals i in MULX/MULC)
//   lut_data  coefficient from the LUT, unsigned Q0.16
//   busy      high while iterating (MULX/MULC)
//   done      one-cycle completion pulse
//   result    e^x, unsigned Q2.16, held until the next accepted start
// ---------------------------------------------------------------------------
module exp_taylor_engine #(
    parameter int N_TERMS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x,
    output logic [3:0]  lut_adr,
    input  logic [15:0] lut_data,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULX = 2'd1,
        MULC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Index of the final iteration.
    localparam logic [3:0] LAST_I = 4'(N_TERMS - 1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] x_r;
    logic [15:0] term;
    logic [15:0] prod;
    logic [17:0] acc;
    logic [3:0]  i;

    // Truncating Q0.16 products. Only the upper 16 bits of each 32-bit
    // product are kept.
    logic [15:0] prod_nx;
    logic [15:0] t;
    logic [17:0] acc_sum;

    always_comb begin
        prod_nx = 16'(({16'd0, term} * {16'd0, x_r}) >> 16);
        t       = 16'(({16'd0, prod} * {16'd0, lut_data}) >> 16);
        acc_sum = acc + {2'b00, t};
    end

    // Next-state and output decode.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        lut_adr  = 4'd0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = MULX;
            end
            MULX: begin
                busy     = 1'b1;
                lut_adr  = i;
                state_nx = MULC;
            end
            MULC: begin
                busy     = 1'b1;
                lut_adr  = i;
                state_nx = (i == LAST_I) ? DONE : MULX;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers.
    // NOTE: sequential state is written with non-blocking assignments only.
    // Every register sees the new values after the edge, whatever order the
    // statements appear in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_r    <= 16'd0;
            term   <= 16'd0;
            prod   <= 16'd0;
            acc    <= 18'd0;
            i      <= 4'd0;
            result <= 18'd0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_r  <= x;
                        term <= 16'hFFFF;   // 1.0 cannot be represented in Q0.16
                        acc  <= 18'h10000;  // exact 1.0 in Q2.16
                        i    <= 4'd0;
                    end
                end
                MULX: begin
                    prod <= prod_nx;
                end
                MULC: begin
                    term <= t;
                    acc  <= acc_sum;
                    if (i == LAST_I) begin
                        // Load the result on the way into DONE so that it
                        // is already valid while done is high.
                        result <= acc_sum;
                    end else begin
                        i <= i + 4'd1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_taylor_engine.sv
// ---------------------------------------------------------------------------
// tb_exp_taylor_engine
//
// Directed bench for exp_taylor_engine. It drives two instances: the default
// N_TERMS=8 and N_TERMS=2. Each instance has its own reciprocal LUT model.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_exp_taylor_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start2;
    logic [15:0] x8, x2;
    logic [3:0]  adr8, adr2;
    logic [15:0] data8, data2;
    logic        busy8, busy2, done8, done2;
    logic [17:0] res8, res2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Reciprocal LUT: 1/(n+1) in Q0.16 (1/1 saturates to FFFF).
    logic [15:0] rom [0:15];
    initial begin
        rom[0] = 16'hFFFF; rom[1] = 16'h8000; rom[2] = 16'h5555; rom[3] = 16'h4000;
        rom[4] = 16'h3333; rom[5] = 16'h2AAA; rom[6] = 16'h2492; rom[7] = 16'h2000;
        for (int k = 8; k < 16; k++) rom[k] = 16'h0000;
    end
    assign data8 = rom[adr8];
    assign data2 = rom[adr2];

    exp_taylor_engine #(.N_TERMS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .lut_adr(adr8),
        .lut_data(data8), .busy(busy8), .done(done8), .result(res8)
    );

    exp_taylor_engine #(.N_TERMS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .x(x2), .lut_adr(adr2),
        .lut_data(data2), .busy(busy2), .done(done2), .result(res2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation on dut8 (sel=0) or dut2 (sel=1) and observe a
    // 40-edge window after the start edge. If mid_pulse > 0, start is
    // re-asserted for one cycle with a different x after that many edges.
    task automatic run_op(input bit sel, input logic [15:0] xv, input int nt,
                          input int mid_pulse,
                          output int lat, output int busy_n, output int done_n,
                          output logic [17:0] res_done, output logic [17:0] res_end,
                          output int adr_bad, output int max_adr);
        logic d, b;
        logic [3:0] a;
        lat = -1; busy_n = 0; done_n = 0; adr_bad = 0; max_adr = 0;
        res_done = 18'h3FFFF;
        if (sel) begin x2 = xv; start2 = 1'b1; end
        else     begin x8 = xv; start8 = 1'b1; end
        tick();                                   // E0 samples start
        start8 = 1'b0; start2 = 1'b0;
        x8 = 16'h1234; x2 = 16'h1234;             // later x changes must not matter
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) tick();
            if (mid_pulse > 0) begin
                if (n == mid_pulse) begin
                    if (sel) start2 = 1'b1; else start8 = 1'b1;
                end else begin
                    start8 = 1'b0; start2 = 1'b0;
                end
            end
            d = sel ? done2 : done8;
            b = sel ? busy2 : busy8;
            a = sel ? adr2  : adr8;
            if (b) busy_n++;
            if (int'(a) > max_adr) max_adr = int'(a);
            // MULC cycles fall at odd n; the address there must be (n-1)/2.
            if (n < 2 * nt && (n % 2) == 1 && int'(a) != (n - 1) / 2) adr_bad++;
            if (d) begin
                done_n++;
                if (lat < 0) begin
                    lat = n;
                    res_done = sel ? res2 : res8;
                end
            end
        end
        res_end = sel ? res2 : res8;
    endtask

    int          lat, busy_n, done_n, adr_bad, max_adr;
    logic [17:0] rd, re;

    initial begin
        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0; x8 = 16'h0; x2 = 16'h0;
        tick(); tick();
        check("rst_busy",   32'(busy8), 32'd0);
        check("rst_done",   32'(done8), 32'd0);
        check("rst_result", 32'(res8),  32'd0);
        check("rst_adr",    32'(adr8),  32'd0);
        rst_n = 1'b1;
        tick();

        // 1: x=0 gives exactly 1.0 with 16-edge latency.
        run_op(1'b0, 16'h0000, 8, 0, lat, busy_n, done_n, rd, re, adr_bad, max_adr);
        check("x0_latency", 32'(lat),    32'd16);
        check("x0_busy_n",  32'(busy_n), 32'd16);
        check("x0_done_n",  32'(done_n), 32'd1);
        check("x0_result",  32'(rd),     32'h10000);

        // 2: x=0.5 gives 1.6486 after truncation.
        run_op(1'b0, 16'h8000, 8, 0, lat, busy_n, done_n, rd, re, adr_bad, max_adr);
        check("xh_latency", 32'(lat),     32'd16);
        check("xh_result",  32'(rd),      32'h1A60C);
        check("xh_hold",    32'(re),      32'h1A60C);
        check("xh_adr_seq", 32'(adr_bad), 32'd0);
        check("xh_max_adr", 32'(max_adr), 32'd7);

        // 3: x just below 1.0 lands slightly under e.
        run_op(1'b0, 16'hFFFF, 8, 0, lat, busy_n, done_n, rd, re, adr_bad, max_adr);
        check("x1_range", 32'(rd >= 18'h2B7C0 && rd <= 18'h2B7DE), 32'd1);
        check("x1_done_n", 32'(done_n), 32'd1);

        // 4: a start pulse while busy is ignored.
        run_op(1'b0, 16'h8000, 8, 5, lat, busy_n, done_n, rd, re, adr_bad, max_adr);
        check("mid_latency", 32'(lat),    32'd16);
        check("mid_result",  32'(re),     32'h1A60C);
        check("mid_done_n",  32'(done_n), 32'd1);

        // 5: reset in MULC at i=3 (7 edges after the start edge).
        x8 = 16'hFFFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("pre_rst_adr",  32'(adr8),  32'd3);
        check("pre_rst_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy",   32'(busy8), 32'd0);
        check("mrst_done",   32'(done8), 32'd0);
        check("mrst_result", 32'(res8),  32'd0);
        check("mrst_adr",    32'(adr8),  32'd0);
        run_op(1'b0, 16'h0000, 8, 0, lat, busy_n, done_n, rd, re, adr_bad, max_adr);
        check("mrst_x0_lat", 32'(lat), 32'd16);
        check("mrst_x0_res", 32'(rd),  32'h10000);

        // 6: N_TERMS=2 instance.
        run_op(1'b1, 16'h8000, 2, 0, lat, busy_n, done_n, rd, re, adr_bad, max_adr);
        check("n2_latency", 32'(lat),     32'd4);
        check("n2_busy_n",  32'(busy_n),  32'd4);
        check("n2_result",  32'(rd),      32'h19FFD);
        check("n2_adr_seq", 32'(adr_bad), 32'd0);
        check("n2_max_adr", 32'(max_adr), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
